// File: rtl/tent_map_pkg.sv
// -----------------------------------------------------------------------------
// tent_map_pkg
// Shared definitions for the tent-map keystream generator:
//   - tent_state_e : FSM state encoding (IDLE, FOLD, MULT, STORE, DONE)
//   - one_q/half_q : Q1.(w-1) constants 1.0 and 0.5 for a given word width w
//   - MU_1P5       : default keystream slope 1.5 for the 80-bit datapath
// -----------------------------------------------------------------------------
package tent_map_pkg;

    // Widest word the Q-constant helpers support.
    localparam int unsigned MAX_W = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FOLD  = 3'd1,
        ST_MULT  = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } tent_state_e;

    // 1.0 in Q1.(w-1): only the integer bit set.
    function automatic logic [MAX_W-1:0] one_q(input int unsigned w);
        logic [MAX_W-1:0] v;
        v = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 32'd1);
        return v;
    endfunction

    // 0.5 in Q1.(w-1): the first fractional bit set.
    function automatic logic [MAX_W-1:0] half_q(input int unsigned w);
        logic [MAX_W-1:0] v;
        v = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 32'd2);
        return v;
    endfunction

    // Slope 1.5 (binary 1.1000...) for the default 80-bit word.
    localparam logic [79:0] MU_1P5 = {2'b11, 78'd0};

endpackage : tent_map_pkg

// File: rtl/tent_mult_seq.sv
// -----------------------------------------------------------------------------
// tent_mult_seq
// Radix-2 shift-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// The first partial product is accumulated on the start edge, so the full
// product is ready and done pulses in the WIDTH-th cycle after start.
// A start while running restarts the multiplication.
// Ports:
//   Clk, Reset_n : clock, asynchronous active-low reset
//   start        : load operands a, b and begin
//   a, b         : unsigned operands
//   product      : 2*WIDTH-bit result, valid when done pulses and held after
//   done         : one-cycle completion pulse
// -----------------------------------------------------------------------------
module tent_mult_seq #(
    parameter int WIDTH = 80
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   a_r;
    logic [2*WIDTH-1:0] p_r;
    logic [CW-1:0]      cnt_r;
    logic               run_r;
    logic               done_r;

    // One shift-add step: the multiplier sits in the low half of p and is
    // consumed LSB first while the accumulator grows in the high half.
    function automatic logic [2*WIDTH-1:0] mac_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] sum;
        if (p[0]) begin
            sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m};
        end else begin
            sum = {1'b0, p[2*WIDTH-1:WIDTH]};
        end
        return {sum, p[WIDTH-1:1]};
    endfunction

    // Operand load, iterative accumulation and completion pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_r    <= '0;
            p_r    <= '0;
            cnt_r  <= '0;
            run_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            a_r    <= a;
            p_r    <= mac_step({{WIDTH{1'b0}}, b}, a);
            cnt_r  <= CW'(WIDTH - 1);
            run_r  <= 1'b1;
            done_r <= 1'b0;
        end else if (run_r) begin
            p_r   <= mac_step(p_r, a_r);
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign product = p_r;
    assign done    = done_r;

endmodule : tent_mult_seq

// File: rtl/tent_map_iter.sv
// -----------------------------------------------------------------------------
// tent_map_iter
// Multi-iteration tent-map keystream generator:
//   x(k+1) = mu * min(x(k), 1 - x(k)),  x and mu in Q1.(WIDTH-1).
// Each iteration is FOLD (1 cycle) + MULT (WIDTH cycles) + STORE (1 cycle).
// Ports:
//   Clk, Reset_n : clock, asynchronous active-low reset
//   start        : run request, honoured only in IDLE or DONE
//   seed, mu     : initial x (clamped to 1.0) and slope, latched on start
//   n_iter       : iterations to run (0 -> straight to DONE)
//   x_out        : current x, registered
//   iter_valid   : one-cycle pulse with each new iterate
//   busy         : high while iterating
//   done         : high in DONE until the next accepted start
// -----------------------------------------------------------------------------
module tent_map_iter
    import tent_map_pkg::*;
#(
    parameter int WIDTH  = 80,
    parameter int ITER_W = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  seed,
    input  logic [WIDTH-1:0]  mu,
    input  logic [ITER_W-1:0] n_iter,
    output logic [WIDTH-1:0]  x_out,
    output logic              iter_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(one_q(WIDTH));
    localparam logic [WIDTH-1:0] HALF_Q = WIDTH'(half_q(WIDTH));

    tent_state_e         state_r;
    logic [WIDTH-1:0]    x_r;
    logic [WIDTH-1:0]    mu_r;
    logic [ITER_W-1:0]   n_r;
    logic [ITER_W-1:0]   count_r;
    logic                iter_valid_r;
    logic                busy_r;
    logic                done_r;

    logic [WIDTH-1:0]    y_s;
    logic [WIDTH-1:0]    seed_clamp_s;
    logic [WIDTH-1:0]    prod_x_s;
    logic [ITER_W-1:0]   count_inc_s;
    logic                mult_start_s;
    logic                mult_done_s;
    logic [2*WIDTH-1:0]  mult_prod_s;

    // Fold, seed clamp and product rescale.
    always_comb begin
        y_s          = x_r;
        seed_clamp_s = seed;
        if (x_r >= HALF_Q) begin
            y_s = ONE_Q - x_r;
        end else begin
            y_s = x_r;
        end
        if (seed > ONE_Q) begin
            seed_clamp_s = ONE_Q;
        end else begin
            seed_clamp_s = seed;
        end
        // Q2.(2W-2) product back to Q1.(W-1): drop W-1 fraction bits, no
        // rounding. The integer bits above are always zero since mu<2, y<=0.5.
        prod_x_s     = WIDTH'(mult_prod_s >> (WIDTH - 1));
        count_inc_s  = count_r + ITER_W'(1);
        mult_start_s = (state_r == ST_FOLD);
    end

    tent_mult_seq #(
        .WIDTH (WIDTH)
    ) u_mult (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (mult_start_s),
        .a       (mu_r),
        .b       (y_s),
        .product (mult_prod_s),
        .done    (mult_done_s)
    );

    // Iteration FSM with registered status outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r      <= ST_IDLE;
            x_r          <= '0;
            mu_r         <= '0;
            n_r          <= '0;
            count_r      <= '0;
            iter_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            iter_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mu_r    <= mu;
                        n_r     <= n_iter;
                        count_r <= '0;
                        x_r     <= seed_clamp_s;
                        if (n_iter != ITER_W'(0)) begin
                            state_r <= ST_FOLD;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end else begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_FOLD: begin
                    state_r <= ST_MULT;
                end
                ST_MULT: begin
                    if (mult_done_s) begin
                        state_r <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    x_r          <= prod_x_s;
                    iter_valid_r <= 1'b1;
                    count_r      <= count_inc_s;
                    if (count_inc_s == n_r) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_FOLD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign x_out      = x_r;
    assign iter_valid = iter_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule : tent_map_iter
